// File: rtl/io_gpio_ctrl.sv
// GPIO bank controller: pad output/enable registers, synchronized and
// debounced pad inputs with edge capture, register port and level irq.
module io_gpio_ctrl #(
  parameter int N_PINS      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [2:0]        req_addr,
  input  logic [N_PINS-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [N_PINS-1:0] rsp_rdata,
  output logic [N_PINS-1:0] c2p,
  output logic [N_PINS-1:0] c2p_en,
  input  logic [N_PINS-1:0] p2c,
  output logic              irq
);

  localparam int N = N_PINS;

  logic                          accept;
  logic                          wr;
  logic [7:0]                    sel;
  logic [N-1:0]                  out_q;
  logic [N-1:0]                  oe_q;
  logic [N-1:0]                  in_q;
  logic [N-1:0]                  prev_q;
  logic [N-1:0]                  rise_q;
  logic [N-1:0]                  fall_q;
  logic [N-1:0]                  ien_q;
  logic [N-1:0]                  sample_q;
  logic [N-1:0]                  sync;
  logic [N-1:0]                  match;
  logic [N-1:0]                  in_d;
  logic [N-1:0]                  set_r;
  logic [N-1:0]                  set_f;
  logic [N-1:0]                  clr_r;
  logic [N-1:0]                  clr_f;
  logic [N-1:0]                  rd_data;
  logic [DEBOUNCE_W-1:0]         deb_q;
  logic [DEBOUNCE_W-1:0]         cnt_q;
  logic [SYNC_STAGES-1:0][N-1:0] sync_q;
  logic [SYNC_STAGES-1:0]        vld_q;
  logic                          tick;
  logic                          load;
  logic                          loaded_q;
  logic                          primed_q;

  assign req_ready = !rsp_valid || rsp_ready;
  assign accept    = req_valid && req_ready;
  assign wr        = accept && req_write;
  assign sel       = wr ? (8'b1 << req_addr) : 8'b0;

  assign c2p    = out_q;
  assign c2p_en = oe_q;

  // vld_q marks when the sync chain carries real pad data, not reset zeros
  assign sync  = sync_q[SYNC_STAGES-1];
  assign tick  = cnt_q == deb_q;
  assign load  = tick && vld_q[SYNC_STAGES-1];
  assign match = ~(sync ^ sample_q);
  assign in_d  = (deb_q == '0) ? sync
               : (in_q & ~match) | (sync & match);

  assign set_r = {N{primed_q}} & in_q & ~prev_q;
  assign set_f = {N{primed_q}} & ~in_q & prev_q;
  assign clr_r = sel[3] ? req_wdata : '0;
  assign clr_f = sel[4] ? req_wdata : '0;

  always_comb begin
    rd_data = '0;
    case (req_addr)
      3'd0:    rd_data = out_q;
      3'd1:    rd_data = oe_q;
      3'd2:    rd_data = in_q;
      3'd3:    rd_data = rise_q;
      3'd4:    rd_data = fall_q;
      3'd5:    rd_data = ien_q;
      3'd6:    rd_data = N'(deb_q);
      default: rd_data = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
      oe_q  <= '0;
      ien_q <= '0;
      deb_q <= '0;
    end else begin
      unique case (1'b1)
        sel[0]:  out_q <= req_wdata;
        sel[1]:  oe_q  <= req_wdata;
        sel[5]:  ien_q <= req_wdata;
        sel[6]:  deb_q <= DEBOUNCE_W'(req_wdata);
        sel[7]:  out_q <= out_q ^ req_wdata;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= '0;
      vld_q    <= '0;
      cnt_q    <= '0;
      sample_q <= '0;
      in_q     <= '0;
      prev_q   <= '0;
      loaded_q <= 1'b0;
      primed_q <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], p2c};
      vld_q    <= {vld_q[SYNC_STAGES-2:0], 1'b1};
      prev_q   <= in_q;
      primed_q <= loaded_q;
      if (sel[6] || tick) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (load) begin
        sample_q <= sync;
        in_q     <= in_d;
        loaded_q <= 1'b1;
      end
    end
  end

  // a new edge wins over a simultaneous write-1-to-clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rise_q <= '0;
      fall_q <= '0;
      irq    <= 1'b0;
    end else begin
      rise_q <= (rise_q & ~clr_r) | set_r;
      fall_q <= (fall_q & ~clr_f) | set_f;
      irq    <= |((rise_q | fall_q) & ien_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else if (accept) begin
      rsp_valid <= 1'b1;
      rsp_rdata <= req_write ? '0 : rd_data;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_io_gpio_ctrl.sv
// Bench for io_gpio_ctrl: directed scenarios with literal expectations
// plus randomized traffic against a behavioural model.
module tb_io_gpio_ctrl;

  localparam int N = 8;
  localparam int S = 2;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_write = 1'b0;
  logic [2:0]   req_addr = '0;
  logic [N-1:0] req_wdata = '0;
  logic         rsp_ready = 1'b1;
  logic [N-1:0] p2c = 8'hFF;
  logic         req_ready;
  logic         rsp_valid;
  logic [N-1:0] rsp_rdata;
  logic [N-1:0] c2p;
  logic [N-1:0] c2p_en;
  logic         irq;

  int checks = 0;
  int errors = 0;

  io_gpio_ctrl #(
    .N_PINS(N),
    .SYNC_STAGES(S),
    .DEBOUNCE_W(W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .c2p(c2p),
    .c2p_en(c2p_en),
    .p2c(p2c),
    .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // behavioural model
  logic [7:0] m_out, m_oe, m_in, m_prev, m_rise, m_fall, m_ien;
  logic [7:0] m_samp, m_rd;
  int         m_cnt, m_deb, m_n, m_first;
  bit         m_rv, m_irq;
  logic [7:0] hq[$];

  task automatic mreset();
    m_out = 0; m_oe = 0; m_in = 0; m_prev = 0; m_rise = 0;
    m_fall = 0; m_ien = 0; m_samp = 0; m_rd = 0;
    m_cnt = 0; m_deb = 0; m_n = 0; m_first = 0;
    m_rv = 0; m_irq = 0;
    hq.delete();
  endtask

  task automatic mstep();
    logic [7:0] syn, rd, clr_r, clr_f, set_r, set_f, nin;
    bit vld, tick, load, acc, wr, ok;
    vld = (hq.size() == S);
    syn = vld ? hq[0] : 8'h00;
    hq.push_back(p2c);
    if (hq.size() > S) void'(hq.pop_front());
    m_n++;
    tick = (m_cnt == m_deb);
    load = tick && vld;
    ok = (m_first > 0) && (m_n >= m_first + 2);
    set_r = ok ? (m_in & ~m_prev) : 8'h00;
    set_f = ok ? (~m_in & m_prev) : 8'h00;
    acc = req_valid && (!m_rv || rsp_ready);
    wr = acc && req_write;
    case (req_addr)
      3'd0: rd = m_out;
      3'd1: rd = m_oe;
      3'd2: rd = m_in;
      3'd3: rd = m_rise;
      3'd4: rd = m_fall;
      3'd5: rd = m_ien;
      3'd6: rd = 8'(m_deb);
      default: rd = 8'h00;
    endcase
    m_irq = |((m_rise | m_fall) & m_ien);
    nin = m_in;
    if (load) begin
      if (m_deb == 0) nin = syn;
      else
        for (int i = 0; i < N; i++)
          if (syn[i] == m_samp[i]) nin[i] = syn[i];
      m_samp = syn;
      if (m_first == 0) m_first = m_n;
    end
    m_prev = m_in;
    m_in = nin;
    clr_r = (wr && req_addr == 3) ? req_wdata : 8'h00;
    clr_f = (wr && req_addr == 4) ? req_wdata : 8'h00;
    m_rise = (m_rise & ~clr_r) | set_r;
    m_fall = (m_fall & ~clr_f) | set_f;
    if (wr && req_addr == 6) m_cnt = 0;
    else if (tick) m_cnt = 0;
    else m_cnt = (m_cnt + 1) % 256;
    if (acc) begin
      m_rv = 1;
      m_rd = req_write ? 8'h00 : rd;
    end else if (rsp_ready) begin
      m_rv = 0;
    end
    if (wr) begin
      case (req_addr)
        3'd0: m_out = req_wdata;
        3'd1: m_oe = req_wdata;
        3'd5: m_ien = req_wdata;
        3'd6: m_deb = int'(req_wdata);
        3'd7: m_out = m_out ^ req_wdata;
        default: ;
      endcase
    end
  endtask

  initial mreset();

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) mreset();
    else mstep();
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("c2p", c2p, m_out);
      chk("c2p_en", c2p_en, m_oe);
      chk("irq", irq, m_irq);
      chk("rsp_valid", rsp_valid, m_rv);
      chk("req_ready", req_ready, !m_rv || rsp_ready);
      if (m_rv) chk("rsp_rdata", rsp_rdata, m_rd);
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_req(input bit w, input logic [2:0] a,
                        input logic [7:0] d, output logic [7:0] r);
    bit acc;
    int b;
    b = 0;
    req_valid = 1; req_write = w; req_addr = a; req_wdata = d;
    do begin
      @(negedge clk);
      acc = req_ready;
      @(posedge clk);
      #1;
      b++;
    end while (!acc && b < 50);
    if (!acc) chk("req_timeout", 0, 1);
    req_valid = 0;
    r = rsp_rdata;
  endtask

  logic [7:0] r;

  initial begin
    #12;
    chk("rst_c2p", c2p, 8'h00);
    chk("rst_c2p_en", c2p_en, 8'h00);
    chk("rst_irq", irq, 0);
    chk("rst_req_ready", req_ready, 1);
    @(negedge clk);
    #1 rst_n = 1;
    idle(2);
    do_req(0, 2, 0, r); chk("in_early", r, 8'h00);
    do_req(0, 2, 0, r); chk("in_latency", r, 8'hFF);
    idle(3);
    do_req(0, 3, 0, r); chk("rise_primed", r, 8'h00);
    do_req(0, 4, 0, r); chk("fall_primed", r, 8'h00);

    do_req(1, 1, 8'h0F, r); chk("oe_c2p_en", c2p_en, 8'h0F);
    do_req(1, 0, 8'hA5, r); chk("out_c2p", c2p, 8'hA5);
    do_req(1, 7, 8'hFF, r); chk("toggle_c2p", c2p, 8'h5A);
    do_req(0, 0, 0, r); chk("out_read", r, 8'h5A);
    do_req(0, 7, 0, r); chk("toggle_read", r, 8'h00);

    p2c = 8'hFE;
    idle(6);
    do_req(1, 4, 8'hFF, r);
    do_req(1, 3, 8'hFF, r);
    do_req(1, 5, 8'h01, r);
    idle(2);
    chk("irq_idle", irq, 0);
    p2c = 8'hFF;
    idle(4); chk("irq_rise_wait", irq, 0);
    idle(1); chk("irq_rise", irq, 1);
    do_req(0, 3, 0, r); chk("rise_set", r, 8'h01);
    do_req(1, 3, 8'h01, r); chk("irq_hold", irq, 1);
    idle(1); chk("irq_clear", irq, 0);

    p2c = 8'hFE;
    idle(6);
    do_req(1, 4, 8'h01, r);
    p2c = 8'hFF;
    idle(3);
    do_req(1, 3, 8'h01, r);
    do_req(0, 3, 0, r); chk("set_wins", r, 8'h01);
    chk("set_wins_irq", irq, 1);

    do_req(1, 6, 8'h04, r);
    do_req(0, 6, 0, r); chk("deb_read", r, 8'h04);
    p2c = 8'hFD;
    idle(30);
    do_req(1, 3, 8'hFF, r);
    do_req(1, 4, 8'hFF, r);
    do_req(0, 2, 0, r); chk("deb_low", r, 8'hFD);
    p2c = 8'hFF;
    idle(3);
    p2c = 8'hFD;
    idle(25);
    do_req(0, 2, 0, r); chk("glitch_in", r, 8'hFD);
    do_req(0, 3, 0, r); chk("glitch_rise", r, 8'h00);
    do_req(0, 4, 0, r); chk("glitch_fall", r, 8'h00);
    p2c = 8'hFF;
    idle(20);
    do_req(0, 2, 0, r); chk("deb_high", r, 8'hFF);
    do_req(0, 3, 0, r); chk("deb_rise", r, 8'h02);

    idle(1);
    rsp_ready = 0;
    do_req(0, 0, 0, r); chk("stall_rdata0", r, 8'h5A);
    for (int i = 0; i < 5; i++) begin
      chk("stall_ready", req_ready, 0);
      chk("stall_valid", rsp_valid, 1);
      chk("stall_rdata", rsp_rdata, 8'h5A);
      idle(1);
    end
    rsp_ready = 1;
    do_req(0, 1, 0, r); chk("b2b_oe", r, 8'h0F);
    chk("b2b_v0", rsp_valid, 1);
    do_req(0, 2, 0, r); chk("b2b_in", r, 8'hFF);
    chk("b2b_v1", rsp_valid, 1);
    do_req(0, 5, 0, r); chk("b2b_ien", r, 8'h01);
    do_req(0, 6, 0, r); chk("b2b_deb", r, 8'h04);
    do_req(1, 2, 8'h00, r); chk("ro_wr_rdata", r, 8'h00);
    chk("ro_wr_valid", rsp_valid, 1);
    do_req(0, 2, 0, r); chk("ro_wr_in", r, 8'hFF);

    do_req(1, 1, 8'hFF, r); chk("oe_ff", c2p_en, 8'hFF);
    idle(1);
    rsp_ready = 0;
    do_req(0, 0, 0, r); chk("pre_rst_valid", rsp_valid, 1);
    #2 rst_n = 0;
    #1;
    chk("arst_valid", rsp_valid, 0);
    chk("arst_c2p_en", c2p_en, 8'h00);
    chk("arst_c2p", c2p, 8'h00);
    rsp_ready = 1;
    @(negedge clk);
    #1 rst_n = 1;
    idle(5);

    for (int i = 0; i < 3000; i++) begin
      req_valid = 1'($urandom % 2);
      req_write = 1'($urandom % 2);
      req_addr  = 3'($urandom % 8);
      req_wdata = (req_addr == 3'd6) ? 8'($urandom % 4) : 8'($urandom);
      rsp_ready = ($urandom % 4) != 0;
      if ($urandom % 8 == 0) p2c = p2c ^ 8'(1 << ($urandom % 8));
      idle(1);
    end
    req_valid = 0;
    rsp_ready = 1;
    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
